pr_dev_bridge: RTL and testbench

//  Parametrised processor-to-device bridge between the multi-cycle CPU core and DEV_CNT peripherals.

---
 rtl/pr_dev_bridge.sv | 196 +++++++++++++++++++
 tb/tb_pr_dev_bridge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pr_dev_bridge.sv
// pr_dev_bridge
//   Processor-to-device bridge between the multi-cycle CPU core and DEV_CNT
//   peripherals. Decodes the device id from PrAddr, runs a req/ready
//   handshake with variable device wait states, answers bad addresses with
//   PrErr, and keeps an interrupt pending/mask register pair that drives the
//   CP0 HWInt lines.
//
//   Optional build macro: BRIDGE_TIMEOUT_EN
//     defined   - an 8-bit wait counter aborts a device access after TIMEOUT
//                 ACCESS cycles with PrErr=1.
//     undefined - ACCESS waits indefinitely for DevReady.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   PrReq/PrWe/PrAddr/PrWD  CPU access strobe, direction, address, write data
//   PrRD/PrReady/PrErr    read data, 1-cycle completion pulse, error flag
//   HWInt                 IPEND & IMASK to CP0
//   DevSel/DevWe/DevAddr/DevWD  one-hot select, write strobe, offset, data
//   DevRD/DevReady/DevIrq per-device read data (packed), done, level irq
module pr_dev_bridge #(
    parameter int unsigned DEV_CNT     = 2,
    parameter int unsigned DEV_ID_WD   = 4,
    parameter int unsigned DEV_ADDR_WD = 4,
    parameter logic [31:0] BASE        = 32'h7f00,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PrReq,
    input  logic                     PrWe,
    input  logic [31:0]              PrAddr,
    input  logic [31:0]              PrWD,
    output logic [31:0]              PrRD,
    output logic                     PrReady,
    output logic                     PrErr,
    output logic [DEV_CNT-1:0]       HWInt,
    output logic [DEV_CNT-1:0]       DevSel,
    output logic                     DevWe,
    output logic [DEV_ADDR_WD-1:0]   DevAddr,
    output logic [31:0]              DevWD,
    input  logic [32*DEV_CNT-1:0]    DevRD,
    input  logic [DEV_CNT-1:0]       DevReady,
    input  logic [DEV_CNT-1:0]       DevIrq
);

    // Parameter legality is checked at elaboration so a bad override fails loudly.
    if (DEV_CNT < 1 || DEV_CNT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("pr_dev_bridge: DEV_CNT or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [DEV_ID_WD-1:0]   BR_ID     = DEV_ID_WD'(DEV_CNT);
    localparam logic [DEV_ADDR_WD-1:0] OFF_IMASK = DEV_ADDR_WD'(0);
    localparam logic [DEV_ADDR_WD-1:0] OFF_IPEND = DEV_ADDR_WD'(4);

    state_t state, state_nx;

    logic [DEV_ID_WD-1:0]   id;
    logic [DEV_ADDR_WD-1:0] off;
    logic                   bad, reg_hit, dev_hit;
    logic [DEV_CNT-1:0]     sel_dec;
    logic [31:0]            reg_rd;
    logic                   rdy_hit;
    logic [31:0]            rd_sel;
    logic                   tmo;
    logic [31:0]            rd_q;
    logic                   err_q;
    logic [DEV_CNT-1:0]     ipend, imask, irq_q, irq_edge, clr;

    // ---------------- address decode ----------------
    always_comb begin
        id      = PrAddr[DEV_ADDR_WD+DEV_ID_WD-1:DEV_ADDR_WD];
        off     = PrAddr[DEV_ADDR_WD-1:0];
        bad     = (PrAddr < BASE) || (id > BR_ID);
        reg_hit = !bad && (id == BR_ID);
        dev_hit = !bad && (id < BR_ID);
        sel_dec = '0;
        for (int unsigned i = 0; i < DEV_CNT; i++) begin
            if (id == DEV_ID_WD'(i)) sel_dec[i] = 1'b1;
        end
        reg_rd = '0;
        if (off == OFF_IMASK)      reg_rd = 32'(imask);
        else if (off == OFF_IPEND) reg_rd = 32'(ipend);
    end

    // Ready/data come only from the device currently selected; others are ignored.
    always_comb begin
        rdy_hit = 1'b0;
        rd_sel  = '0;
        for (int unsigned i = 0; i < DEV_CNT; i++) begin
            if (DevSel[i]) begin
                rdy_hit = DevReady[i];
                rd_sel  = DevRD[32*i +: 32];
            end
        end
    end

    // ---------------- interrupts ----------------
    always_comb begin
        irq_edge = DevIrq & ~irq_q;
        clr      = '0;
        if (state == IDLE && PrReq && reg_hit && PrWe && off == OFF_IPEND)
            clr = PrWD[DEV_CNT-1:0];
    end

`ifdef BRIDGE_TIMEOUT_EN
    logic [7:0] cnt;
    assign tmo = (cnt == 8'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (PrReq) state_nx = dev_hit ? ACCESS : DONE;
            ACCESS:  if (rdy_hit || tmo) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        PrReady = (state == DONE);
        PrRD    = (state == DONE) ? rd_q : '0;
        PrErr   = (state == DONE) && err_q;
        HWInt   = ipend & imask;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DevSel  <= '0;
            DevWe   <= 1'b0;
            DevAddr <= '0;
            DevWD   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            ipend   <= '0;
            imask   <= '1;
            irq_q   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            irq_q <= DevIrq;
            // New edge is OR'd in after the clear so a coincident set wins.
            ipend <= (ipend & ~clr) | irq_edge;
            unique case (state)
                IDLE: if (PrReq) begin
                    if (dev_hit) begin
                        DevSel  <= sel_dec;
                        DevWe   <= PrWe;
                        DevAddr <= off;
                        DevWD   <= PrWD;
`ifdef BRIDGE_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end else begin
                        err_q <= bad;
                        rd_q  <= bad ? '0 : reg_rd;
                        if (reg_hit && PrWe && off == OFF_IMASK)
                            imask <= PrWD[DEV_CNT-1:0];
                    end
                end
                ACCESS: begin
                    if (rdy_hit) begin
                        rd_q   <= rd_sel;
                        err_q  <= 1'b0;
                        DevSel <= '0;
                        DevWe  <= 1'b0;
                    end else if (tmo) begin
                        rd_q   <= '0;
                        err_q  <= 1'b1;
                        DevSel <= '0;
                        DevWe  <= 1'b0;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    cnt <= cnt + 8'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_dev_bridge.sv
// Directed bench for pr_dev_bridge with default parameters (DEV_CNT=2,
// BASE=0x7f00, 16-byte windows: dev0 0x7f0x, dev1 0x7f1x, bridge regs 0x7f2x).
module tb_pr_dev_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        PrReq, PrWe;
    logic [31:0] PrAddr, PrWD, PrRD;
    logic        PrReady, PrErr;
    logic [1:0]  HWInt, DevSel;
    logic        DevWe;
    logic [3:0]  DevAddr;
    logic [31:0] DevWD;
    logic [63:0] DevRD;
    logic [1:0]  DevReady, DevIrq;

    int n_vec = 0;
    int n_bad = 0;

    pr_dev_bridge #(
        .DEV_CNT(2), .DEV_ID_WD(4), .DEV_ADDR_WD(4), .BASE(32'h7f00), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .PrReq(PrReq), .PrWe(PrWe), .PrAddr(PrAddr), .PrWD(PrWD),
        .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .HWInt(HWInt),
        .DevSel(DevSel), .DevWe(DevWe), .DevAddr(DevAddr), .DevWD(DevWD),
        .DevRD(DevRD), .DevReady(DevReady), .DevIrq(DevIrq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        PrReq  = 1'b1;
        PrWe   = we;
        PrAddr = addr;
        PrWD   = wd;
    endtask

    // Bridge-register or bad-address access: completes one edge after PrReq.
    task automatic bus_reg(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input bit chk_rd,
                           input logic [31:0] exp_rd, input logic exp_err);
        req(we, addr, wd);
        tick();
        check({tag, "_rdy"}, 32'(PrReady), 32'd1);
        check({tag, "_err"}, 32'(PrErr), 32'(exp_err));
        check({tag, "_sel"}, 32'(DevSel), 32'd0);
        if (chk_rd) check({tag, "_rd"}, PrRD, exp_rd);
        PrReq = 1'b0;
        tick();
        check({tag, "_rdy_off"}, 32'(PrReady), 32'd0);
    endtask

    initial begin
        rst = 1'b1; PrReq = 1'b0; PrWe = 1'b0; PrAddr = '0; PrWD = '0;
        DevRD = {32'hDEAD0002, 32'hCAFE0001}; DevReady = '0; DevIrq = '0;
        tick(); tick();

        // Reset state
        check("rst_rdy",   32'(PrReady), 32'd0);
        check("rst_err",   32'(PrErr),   32'd0);
        check("rst_rd",    PrRD,         32'd0);
        check("rst_sel",   32'(DevSel),  32'd0);
        check("rst_we",    32'(DevWe),   32'd0);
        check("rst_addr",  32'(DevAddr), 32'd0);
        check("rst_wd",    DevWD,        32'd0);
        check("rst_hwint", 32'(HWInt),   32'd0);
        rst = 1'b0;
        tick();

        // 1: zero-wait read of dev0 offset 4
        req(1'b0, 32'h7f04, 32'h0);
        DevReady = 2'b01;
        tick();
        check("t1_sel",     32'(DevSel),  32'h1);
        check("t1_addr",    32'(DevAddr), 32'h4);
        check("t1_rdy_c2",  32'(PrReady), 32'd0);
        tick();
        check("t1_rdy",     32'(PrReady), 32'd1);
        check("t1_rd",      PrRD,         32'hCAFE0001);
        check("t1_err",     32'(PrErr),   32'd0);
        check("t1_sel_off", 32'(DevSel),  32'd0);
        PrReq = 1'b0; DevReady = '0;
        tick();
        check("t1_rdy_off", 32'(PrReady), 32'd0);
        check("t1_rd_off",  PrRD,         32'd0);

        // 2: write dev1 offset 8, four waits; dev0 ready meanwhile must be ignored
        req(1'b1, 32'h7f18, 32'h12345678);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t2_sel",  32'(DevSel),  32'h2);
            check("t2_we",   32'(DevWe),   32'd1);
            check("t2_addr", 32'(DevAddr), 32'h8);
            check("t2_wd",   DevWD,        32'h12345678);
            check("t2_rdy",  32'(PrReady), 32'd0);
            DevReady = (k == 4) ? 2'b10 : 2'b01;
            tick();
        end
        check("t2_done",    32'(PrReady), 32'd1);
        check("t2_err",     32'(PrErr),   32'd0);
        check("t2_sel_off", 32'(DevSel),  32'd0);
        check("t2_we_off",  32'(DevWe),   32'd0);
        PrReq = 1'b0; DevReady = '0;
        tick();
        check("t2_rdy_off", 32'(PrReady), 32'd0);

        // 3: bad addresses (id above bridge window, below BASE) and unmapped reg offset
        bus_reg("t3_id3",  1'b0, 32'h7f30, 32'h0, 1'b1, 32'h0, 1'b1);
        bus_reg("t3_low",  1'b0, 32'h0f04, 32'h0, 1'b1, 32'h0, 1'b1);
        check("t3_err_off", 32'(PrErr), 32'd0);
        bus_reg("t3_off8", 1'b0, 32'h7f28, 32'h0, 1'b1, 32'h0, 1'b0);

        // 4: interrupts
        bus_reg("t4_imask_rst", 1'b0, 32'h7f20, 32'h0, 1'b1, 32'h3, 1'b0);
        bus_reg("t4_ipend_rst", 1'b0, 32'h7f24, 32'h0, 1'b1, 32'h0, 1'b0);
        DevIrq = 2'b10;
        tick();
        check("t4_hwint_set", 32'(HWInt), 32'h2);
        bus_reg("t4_ipend_set", 1'b0, 32'h7f24, 32'h0, 1'b1, 32'h2, 1'b0);
        bus_reg("t4_wr_mask",   1'b1, 32'h7f20, 32'h1, 1'b0, 32'h0, 1'b0);
        check("t4_hwint_masked", 32'(HWInt), 32'h0);
        bus_reg("t4_w1c",       1'b1, 32'h7f24, 32'h2, 1'b0, 32'h0, 1'b0);
        bus_reg("t4_ipend_clr", 1'b0, 32'h7f24, 32'h0, 1'b1, 32'h0, 1'b0);
        DevIrq = 2'b00;
        tick();
        DevIrq = 2'b10;
        bus_reg("t4_w1c_race",  1'b1, 32'h7f24, 32'h2, 1'b0, 32'h0, 1'b0);
        bus_reg("t4_ipend_race", 1'b0, 32'h7f24, 32'h0, 1'b1, 32'h2, 1'b0);
        bus_reg("t4_wr_mask3",  1'b1, 32'h7f20, 32'h3, 1'b0, 32'h0, 1'b0);
        check("t4_hwint_unmask", 32'(HWInt), 32'h2);

`ifdef BRIDGE_TIMEOUT_EN
        // 5: dev0 never ready -> error after 16 ACCESS cycles
        req(1'b0, 32'h7f04, 32'h0);
        DevReady = '0;
        tick();
        for (int k = 0; k < 16; k++) begin
            check("t5_wait", 32'(PrReady), 32'd0);
            tick();
        end
        check("t5_rdy", 32'(PrReady), 32'd1);
        check("t5_err", 32'(PrErr),   32'd1);
        check("t5_rd",  PrRD,         32'd0);
        check("t5_sel", 32'(DevSel),  32'd0);
        PrReq = 1'b0;
        tick();
`endif

        // 6: reset during ACCESS
        bus_reg("t6_wr_mask", 1'b1, 32'h7f20, 32'h1, 1'b0, 32'h0, 1'b0);
        req(1'b0, 32'h7f04, 32'h0);
        DevReady = '0;
        tick();
        check("t6_sel_acc", 32'(DevSel), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_sel_rst",   32'(DevSel),  32'd0);
        check("t6_rdy_rst",   32'(PrReady), 32'd0);
        check("t6_hwint_rst", 32'(HWInt),   32'd0);
        #1 rst = 1'b0;
        PrReq = 1'b0;
        tick();
        check("t6_no_rdy", 32'(PrReady), 32'd0);
        bus_reg("t6_imask", 1'b0, 32'h7f20, 32'h0, 1'b1, 32'h3, 1'b0);
        DevRD = {32'hDEAD0002, 32'h600D0001};
        req(1'b0, 32'h7f04, 32'h0);
        DevReady = 2'b01;
        tick();
        tick();
        check("t6_rdy", 32'(PrReady), 32'd1);
        check("t6_rd",  PrRD,         32'h600D0001);
        check("t6_err", 32'(PrErr),   32'd0);
        PrReq = 1'b0; DevReady = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
